// File: rtl/board_state_flood.sv
// Minefield store for a GRID_W x GRID_H board with per-cell mine/flag/revealed maps,
// a stack-based flood-reveal engine, running counts and win/loss status.
module board_state_flood #(
    parameter  int GRID_W      = 16,
    parameter  int GRID_H      = 16,
    parameter  int XW          = 4,
    parameter  int YW          = 4,
    parameter  int STACK_DEPTH = 64,
    localparam int AW          = XW + YW,
    localparam int CW          = $clog2(GRID_W * GRID_H + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_debug_reveal,
    input  logic          i_mine_wr_en,
    input  logic [AW-1:0] i_mine_wr_addr,
    input  logic          i_mine_wr_data,
    input  logic          i_flag_tog_en,
    input  logic [AW-1:0] i_flag_tog_addr,
    input  logic          i_reveal_req,
    input  logic [AW-1:0] i_reveal_addr,
    output logic          o_reveal_busy,
    input  logic [XW-1:0] i_rd_x,
    input  logic [YW-1:0] i_rd_y,
    output logic          o_rd_mine,
    output logic          o_rd_flag,
    output logic          o_rd_revealed,
    output logic [3:0]    o_rd_adj,
    input  logic [AW-1:0] i_cursor_addr,
    output logic          o_cur_mine,
    output logic          o_cur_flag,
    output logic          o_cur_revealed,
    output logic [CW-1:0] o_mine_count,
    output logic [CW-1:0] o_flag_count,
    output logic [CW-1:0] o_safe_count,
    output logic          o_hit_mine,
    output logic          o_won,
    output logic          o_overflow
);
    localparam int NCELL = 2 ** AW;
    localparam int SIW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SPW   = $clog2(STACK_DEPTH + 1);
    localparam logic [CW-1:0] TOTAL = CW'(GRID_W * GRID_H);

    typedef enum logic [1:0] {IDLE, POP, SCAN} state_t;

    state_t         r_state;
    logic [NCELL-1:0] r_mine, r_flag, r_rev;
    logic [AW-1:0]  r_stack [STACK_DEPTH];
    logic [SPW-1:0] r_sp;
    logic [AW-1:0]  r_cur;
    logic [2:0]     r_nb;
    logic [CW-1:0]  r_mineCount, r_flagCount, r_safeCount;
    logic           r_busy, r_hit, r_won, r_ovf;

    function automatic logic inGrid(input logic [AW-1:0] a);
        return (int'(a[XW-1:0]) < GRID_W) && (int'(a[AW-1:XW]) < GRID_H);
    endfunction

    // Counts mines among the in-grid neighbours of a cell, excluding the cell itself.
    function automatic logic [3:0] adjOf(input logic [NCELL-1:0] mines, input logic [AW-1:0] a);
        logic [3:0] n;
        int cx, cy, nx, ny;
        n  = 4'd0;
        cx = int'(a[XW-1:0]);
        cy = int'(a[AW-1:XW]);
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                nx = cx + dx;
                ny = cy + dy;
                if ((dx != 0 || dy != 0) && nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H)
                    n = n + {3'd0, mines[{YW'(ny), XW'(nx)}]};
            end
        end
        return n;
    endfunction

    logic [AW-1:0]  w_rdAddr, w_top, w_nbAddr;
    logic           w_rdIn, w_curIn, w_nbIn, w_nbOk, w_full, w_gameOver;
    logic           w_mineAcc, w_flagAcc, w_revAcc, w_pushSeed, w_pushNb;
    logic [SIW-1:0] w_topIdx, w_pushIdx;
    logic [3:0]     w_topAdj;
    int             w_dx, w_dy, w_nx, w_ny;

    assign w_rdAddr       = {i_rd_y, i_rd_x};
    assign w_rdIn         = inGrid(w_rdAddr);
    assign w_curIn        = inGrid(i_cursor_addr);
    assign o_rd_mine      = w_rdIn & r_mine[w_rdAddr];
    assign o_rd_flag      = w_rdIn & r_flag[w_rdAddr];
    assign o_rd_revealed  = i_debug_reveal | (w_rdIn & r_rev[w_rdAddr]);
    assign o_rd_adj       = w_rdIn ? adjOf(r_mine, w_rdAddr) : 4'd0;
    assign o_cur_mine     = w_curIn & r_mine[i_cursor_addr];
    assign o_cur_flag     = w_curIn & r_flag[i_cursor_addr];
    assign o_cur_revealed = w_curIn & r_rev[i_cursor_addr];

    assign o_reveal_busy = r_busy;
    assign o_mine_count  = r_mineCount;
    assign o_flag_count  = r_flagCount;
    assign o_safe_count  = r_safeCount;
    assign o_hit_mine    = r_hit;
    assign o_won         = r_won;
    assign o_overflow    = r_ovf;

    assign w_gameOver = r_hit | r_won;
    assign w_full     = (r_sp == SPW'(STACK_DEPTH));
    assign w_topIdx   = SIW'(r_sp - SPW'(1));
    assign w_pushIdx  = SIW'(r_sp);
    assign w_top      = r_stack[w_topIdx];
    assign w_topAdj   = adjOf(r_mine, w_top);

    assign w_mineAcc = i_mine_wr_en && (r_state == IDLE) && inGrid(i_mine_wr_addr);
    assign w_flagAcc = i_flag_tog_en && (r_state == IDLE) && !w_gameOver
                       && inGrid(i_flag_tog_addr) && !r_rev[i_flag_tog_addr];
    // A flag being placed on the seed in the same cycle blocks the reveal like an existing flag.
    assign w_revAcc  = i_reveal_req && (r_state == IDLE) && !w_gameOver && inGrid(i_reveal_addr)
                       && !r_flag[i_reveal_addr] && !r_rev[i_reveal_addr]
                       && !(w_flagAcc && (i_flag_tog_addr == i_reveal_addr));
    assign w_pushSeed = w_revAcc && !r_mine[i_reveal_addr];
    assign w_pushNb   = (r_state == SCAN) && w_nbOk && !w_full;

    always_comb begin
        w_dx = 0;
        w_dy = 0;
        case (r_nb)
            3'd0:    begin w_dx = -1; w_dy = -1; end
            3'd1:    begin w_dx =  0; w_dy = -1; end
            3'd2:    begin w_dx =  1; w_dy = -1; end
            3'd3:    begin w_dx = -1; w_dy =  0; end
            3'd4:    begin w_dx =  1; w_dy =  0; end
            3'd5:    begin w_dx = -1; w_dy =  1; end
            3'd6:    begin w_dx =  0; w_dy =  1; end
            default: begin w_dx =  1; w_dy =  1; end
        endcase
        w_nx     = int'(r_cur[XW-1:0]) + w_dx;
        w_ny     = int'(r_cur[AW-1:XW]) + w_dy;
        w_nbIn   = (w_nx >= 0) && (w_nx < GRID_W) && (w_ny >= 0) && (w_ny < GRID_H);
        w_nbAddr = {YW'(w_ny), XW'(w_nx)};
        w_nbOk   = w_nbIn && !r_rev[w_nbAddr] && !r_flag[w_nbAddr] && !r_mine[w_nbAddr];
    end

    // Stack storage needs no reset: the stack pointer alone defines what is valid.
    always_ff @(posedge i_clk) begin
        if (w_pushSeed)
            r_stack[0] <= i_reveal_addr;
        else if (w_pushNb)
            r_stack[w_pushIdx] <= w_nbAddr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;  r_mine <= '0;  r_flag <= '0;  r_rev <= '0;
            r_sp <= '0;  r_cur <= '0;  r_nb <= '0;
            r_mineCount <= '0;  r_flagCount <= '0;  r_safeCount <= '0;
            r_busy <= 1'b0;  r_hit <= 1'b0;  r_won <= 1'b0;  r_ovf <= 1'b0;
        end else if (i_clear) begin
            r_state <= IDLE;  r_mine <= '0;  r_flag <= '0;  r_rev <= '0;
            r_sp <= '0;  r_cur <= '0;  r_nb <= '0;
            r_mineCount <= '0;  r_flagCount <= '0;  r_safeCount <= '0;
            r_busy <= 1'b0;  r_hit <= 1'b0;  r_won <= 1'b0;  r_ovf <= 1'b0;
        end else begin
            if (w_mineAcc) begin
                r_mine[i_mine_wr_addr] <= i_mine_wr_data;
                if (i_mine_wr_data && !r_mine[i_mine_wr_addr])
                    r_mineCount <= r_mineCount + CW'(1);
                else if (!i_mine_wr_data && r_mine[i_mine_wr_addr])
                    r_mineCount <= r_mineCount - CW'(1);
            end
            if (w_flagAcc) begin
                r_flag[i_flag_tog_addr] <= !r_flag[i_flag_tog_addr];
                r_flagCount <= r_flag[i_flag_tog_addr] ? r_flagCount - CW'(1) : r_flagCount + CW'(1);
            end
            r_won <= (r_mineCount != '0) && !r_hit && (r_safeCount == TOTAL - r_mineCount);
            case (r_state)
                IDLE: begin
                    if (w_revAcc) begin
                        r_rev[i_reveal_addr] <= 1'b1;
                        if (r_mine[i_reveal_addr]) begin
                            r_hit <= 1'b1;
                        end else begin
                            r_safeCount <= r_safeCount + CW'(1);
                            r_sp        <= SPW'(1);
                            r_state     <= POP;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                POP: begin
                    if (r_sp == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sp  <= r_sp - SPW'(1);
                        r_cur <= w_top;
                        if (w_topAdj == 4'd0) begin
                            r_state <= SCAN;
                            r_nb    <= 3'd0;
                        end
                    end
                end
                SCAN: begin
                    // A qualifying neighbour that finds the stack full stays unrevealed.
                    if (w_nbOk) begin
                        if (w_full) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_rev[w_nbAddr] <= 1'b1;
                            r_safeCount     <= r_safeCount + CW'(1);
                            r_sp            <= r_sp + SPW'(1);
                        end
                    end
                    r_nb <= r_nb + 3'd1;
                    if (r_nb == 3'd7)
                        r_state <= POP;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_board_state_flood.sv
// Self-checking bench for board_state_flood: three instances (16x16 deep stack, 16x16 with a
// 4-entry stack, 9x9 board) share one stimulus bus; reveal outcomes go through a scoreboard queue.
module tb_board_state_flood;
    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       clear = 1'b0, dbg = 1'b0;
    logic       mineWrEn = 1'b0, mineWrData = 1'b0;
    logic [7:0] mineWrAddr = '0;
    logic       flagTogEn = 1'b0;
    logic [7:0] flagTogAddr = '0;
    logic       revealReq = 1'b0;
    logic [7:0] revealAddr = '0;
    logic [3:0] rdX = '0, rdY = '0;
    logic [7:0] cursorAddr = '0;

    logic       aBusy, aRdMine, aRdFlag, aRdRev, aCurMine, aCurFlag, aCurRev, aHit, aWon, aOvf;
    logic [3:0] aRdAdj;
    logic [8:0] aMineCnt, aFlagCnt, aSafeCnt;
    logic       sBusy, sRdMine, sRdFlag, sRdRev, sCurMine, sCurFlag, sCurRev, sHit, sWon, sOvf;
    logic [3:0] sRdAdj;
    logic [8:0] sMineCnt, sFlagCnt, sSafeCnt;
    logic       nBusy, nRdMine, nRdFlag, nRdRev, nCurMine, nCurFlag, nCurRev, nHit, nWon, nOvf;
    logic [3:0] nRdAdj;
    logic [6:0] nMineCnt, nFlagCnt, nSafeCnt;

    typedef struct packed {
        logic [8:0] safe;
        logic       hit;
        logic       won;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    int nChecks = 0;
    int nFails  = 0;

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    board_state_flood #(.STACK_DEPTH(256)) uA (
        .i_clk(clk), .i_rst_n(rstN), .i_clear(clear), .i_debug_reveal(dbg),
        .i_mine_wr_en(mineWrEn), .i_mine_wr_addr(mineWrAddr), .i_mine_wr_data(mineWrData),
        .i_flag_tog_en(flagTogEn), .i_flag_tog_addr(flagTogAddr),
        .i_reveal_req(revealReq), .i_reveal_addr(revealAddr), .o_reveal_busy(aBusy),
        .i_rd_x(rdX), .i_rd_y(rdY), .o_rd_mine(aRdMine), .o_rd_flag(aRdFlag),
        .o_rd_revealed(aRdRev), .o_rd_adj(aRdAdj), .i_cursor_addr(cursorAddr),
        .o_cur_mine(aCurMine), .o_cur_flag(aCurFlag), .o_cur_revealed(aCurRev),
        .o_mine_count(aMineCnt), .o_flag_count(aFlagCnt), .o_safe_count(aSafeCnt),
        .o_hit_mine(aHit), .o_won(aWon), .o_overflow(aOvf));

    board_state_flood #(.STACK_DEPTH(4)) uS (
        .i_clk(clk), .i_rst_n(rstN), .i_clear(clear), .i_debug_reveal(dbg),
        .i_mine_wr_en(mineWrEn), .i_mine_wr_addr(mineWrAddr), .i_mine_wr_data(mineWrData),
        .i_flag_tog_en(flagTogEn), .i_flag_tog_addr(flagTogAddr),
        .i_reveal_req(revealReq), .i_reveal_addr(revealAddr), .o_reveal_busy(sBusy),
        .i_rd_x(rdX), .i_rd_y(rdY), .o_rd_mine(sRdMine), .o_rd_flag(sRdFlag),
        .o_rd_revealed(sRdRev), .o_rd_adj(sRdAdj), .i_cursor_addr(cursorAddr),
        .o_cur_mine(sCurMine), .o_cur_flag(sCurFlag), .o_cur_revealed(sCurRev),
        .o_mine_count(sMineCnt), .o_flag_count(sFlagCnt), .o_safe_count(sSafeCnt),
        .o_hit_mine(sHit), .o_won(sWon), .o_overflow(sOvf));

    board_state_flood #(.GRID_W(9), .GRID_H(9)) uN (
        .i_clk(clk), .i_rst_n(rstN), .i_clear(clear), .i_debug_reveal(dbg),
        .i_mine_wr_en(mineWrEn), .i_mine_wr_addr(mineWrAddr), .i_mine_wr_data(mineWrData),
        .i_flag_tog_en(flagTogEn), .i_flag_tog_addr(flagTogAddr),
        .i_reveal_req(revealReq), .i_reveal_addr(revealAddr), .o_reveal_busy(nBusy),
        .i_rd_x(rdX), .i_rd_y(rdY), .o_rd_mine(nRdMine), .o_rd_flag(nRdFlag),
        .o_rd_revealed(nRdRev), .o_rd_adj(nRdAdj), .i_cursor_addr(cursorAddr),
        .o_cur_mine(nCurMine), .o_cur_flag(nCurFlag), .o_cur_revealed(nCurRev),
        .o_mine_count(nMineCnt), .o_flag_count(nFlagCnt), .o_safe_count(nSafeCnt),
        .o_hit_mine(nHit), .o_won(nWon), .o_overflow(nOvf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doClear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic writeMine(input int x, input int y, input logic d);
        mineWrEn = 1'b1; mineWrAddr = {4'(y), 4'(x)}; mineWrData = d;
        tick();
        mineWrEn = 1'b0;
    endtask

    task automatic toggleFlag(input int x, input int y);
        flagTogEn = 1'b1; flagTogAddr = {4'(y), 4'(x)};
        tick();
        flagTogEn = 1'b0;
    endtask

    task automatic startReveal(input int x, input int y);
        revealReq = 1'b1; revealAddr = {4'(y), 4'(x)};
        tick();
        revealReq = 1'b0;
    endtask

    task automatic setRd(input int x, input int y);
        rdX = 4'(x); rdY = 4'(y);
        #1;
    endtask

    task automatic waitIdle(input int sel, input int budget, output bit ok);
        logic b;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            b = (sel == 0) ? aBusy : (sel == 1) ? sBusy : nBusy;
            if (!b) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        nChecks++; if ({aBusy, aHit, aWon, aOvf} !== 4'b0) begin nFails++; $display("[TB] FAIL reset_status: got %b want 0000", {aBusy, aHit, aWon, aOvf}); end
        nChecks++; if (aMineCnt !== 9'd0) begin nFails++; $display("[TB] FAIL reset_mine_count: got %0d want 0", aMineCnt); end
        nChecks++; if (aSafeCnt !== 9'd0) begin nFails++; $display("[TB] FAIL reset_safe_count: got %0d want 0", aSafeCnt); end
        nChecks++; if (aFlagCnt !== 9'd0) begin nFails++; $display("[TB] FAIL reset_flag_count: got %0d want 0", aFlagCnt); end
        setRd(0, 0);
        nChecks++; if ({aRdMine, aRdFlag, aRdRev, aRdAdj} !== 7'd0) begin nFails++; $display("[TB] FAIL reset_read: got %b want 0", {aRdMine, aRdFlag, aRdRev, aRdAdj}); end
    endtask

    task automatic test_clear_mid_flood();
        doClear();
        writeMine(0, 0, 1'b1);
        startReveal(15, 15);
        repeat (20) tick();
        nChecks++; if (aBusy !== 1'b1) begin nFails++; $display("[TB] FAIL busy_mid_flood: got %b want 1", aBusy); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        nChecks++; if (aBusy !== 1'b0) begin nFails++; $display("[TB] FAIL clear_busy: got %b want 0", aBusy); end
        nChecks++; if ({aHit, aWon, aOvf, aSafeCnt, aMineCnt} !== 21'd0) begin nFails++; $display("[TB] FAIL clear_state: got safe=%0d mine=%0d want 0", aSafeCnt, aMineCnt); end
        setRd(15, 15);
        nChecks++; if (aRdRev !== 1'b0) begin nFails++; $display("[TB] FAIL clear_seed_revealed: got %b want 0", aRdRev); end
        repeat (5) tick();
        nChecks++; if (aSafeCnt !== 9'd0) begin nFails++; $display("[TB] FAIL clear_no_more_reveals: got %0d want 0", aSafeCnt); end
        // Asynchronous reset in the middle of a flood, applied away from any clock edge.
        writeMine(0, 0, 1'b1);
        startReveal(15, 15);
        repeat (20) tick();
        #2 rstN = 1'b0;
        #1;
        nChecks++; if ({aBusy, aSafeCnt, aMineCnt} !== 19'd0) begin nFails++; $display("[TB] FAIL async_reset: got busy=%b safe=%0d mine=%0d want 0", aBusy, aSafeCnt, aMineCnt); end
        #2 rstN = 1'b1;
        repeat (5) tick();
        setRd(14, 14);
        nChecks++; if ({aRdRev, aSafeCnt} !== 10'd0) begin nFails++; $display("[TB] FAIL after_reset: got rev=%b safe=%0d want 0", aRdRev, aSafeCnt); end
    endtask

    task automatic test_full_flood();
        bit ok;
        doClear();
        writeMine(0, 0, 1'b1);
        nChecks++; if (aMineCnt !== 9'd1) begin nFails++; $display("[TB] FAIL flood_mine_count: got %0d want 1", aMineCnt); end
        e = '{safe: 9'd255, hit: 1'b0, won: 1'b1};
        sbq.push_back(e);
        startReveal(15, 15);
        waitIdle(0, 5000, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL flood_timeout: busy=%b want 0", aBusy); end
        e = sbq.pop_front();
        nChecks++; if (aSafeCnt !== e.safe) begin nFails++; $display("[TB] FAIL flood_safe: got %0d want %0d", aSafeCnt, e.safe); end
        nChecks++; if ({aHit, aWon} !== {e.hit, e.won}) begin nFails++; $display("[TB] FAIL flood_status: got hit=%b won=%b want %b %b", aHit, aWon, e.hit, e.won); end
        nChecks++; if (aOvf !== 1'b0) begin nFails++; $display("[TB] FAIL flood_overflow: got %b want 0", aOvf); end
        setRd(0, 0);
        nChecks++; if ({aRdMine, aRdRev} !== 2'b10) begin nFails++; $display("[TB] FAIL flood_mine_cell: got %b want 10", {aRdMine, aRdRev}); end
        setRd(1, 1);
        nChecks++; if ({aRdRev, aRdAdj} !== 5'b1_0001) begin nFails++; $display("[TB] FAIL flood_adj_cell: got rev=%b adj=%0d want 1 1", aRdRev, aRdAdj); end
    endtask

    task automatic test_numbered_and_hit();
        doClear();
        writeMine(5, 5, 1'b1);
        writeMine(5, 5, 1'b1);
        nChecks++; if (aMineCnt !== 9'd1) begin nFails++; $display("[TB] FAIL rewrite_mine_count: got %0d want 1", aMineCnt); end
        e = '{safe: 9'd1, hit: 1'b0, won: 1'b0};
        sbq.push_back(e);
        startReveal(4, 4);
        nChecks++; if (aBusy !== 1'b1) begin nFails++; $display("[TB] FAIL busy_cycle1: got %b want 1", aBusy); end
        tick();
        nChecks++; if (aBusy !== 1'b1) begin nFails++; $display("[TB] FAIL busy_cycle2: got %b want 1", aBusy); end
        tick();
        nChecks++; if (aBusy !== 1'b0) begin nFails++; $display("[TB] FAIL busy_cycle3: got %b want 0", aBusy); end
        e = sbq.pop_front();
        nChecks++; if ({aSafeCnt, aHit, aWon} !== {e.safe, e.hit, e.won}) begin nFails++; $display("[TB] FAIL numbered_result: got safe=%0d hit=%b won=%b want %0d", aSafeCnt, aHit, aWon, e.safe); end
        setRd(4, 4);
        nChecks++; if ({aRdRev, aRdAdj} !== 5'b1_0001) begin nFails++; $display("[TB] FAIL numbered_adj: got rev=%b adj=%0d want 1 1", aRdRev, aRdAdj); end
        setRd(3, 3);
        nChecks++; if (aRdRev !== 1'b0) begin nFails++; $display("[TB] FAIL numbered_no_spread: got %b want 0", aRdRev); end
        e = '{safe: 9'd1, hit: 1'b1, won: 1'b0};
        sbq.push_back(e);
        startReveal(5, 5);
        tick();
        e = sbq.pop_front();
        nChecks++; if ({aSafeCnt, aHit, aWon} !== {e.safe, e.hit, e.won}) begin nFails++; $display("[TB] FAIL hit_result: got safe=%0d hit=%b won=%b want %0d %b", aSafeCnt, aHit, aWon, e.safe, e.hit); end
        // In game over, flag toggles and reveals are ignored but mine writes still land.
        toggleFlag(7, 7);
        startReveal(3, 3);
        nChecks++; if ({aFlagCnt, aSafeCnt, aBusy} !== {9'd0, 9'd1, 1'b0}) begin nFails++; $display("[TB] FAIL game_over_ignore: got flags=%0d safe=%0d want 0 1", aFlagCnt, aSafeCnt); end
        writeMine(5, 5, 1'b0);
        nChecks++; if (aMineCnt !== 9'd0) begin nFails++; $display("[TB] FAIL mine_clear_count: got %0d want 0", aMineCnt); end
    endtask

    task automatic test_flags();
        bit ok;
        doClear();
        writeMine(0, 0, 1'b1);
        toggleFlag(10, 10);
        nChecks++; if (aFlagCnt !== 9'd1) begin nFails++; $display("[TB] FAIL flag_count_set: got %0d want 1", aFlagCnt); end
        e = '{safe: 9'd0, hit: 1'b0, won: 1'b0};
        sbq.push_back(e);
        startReveal(10, 10);
        e = sbq.pop_front();
        nChecks++; if ({aSafeCnt, aBusy} !== {e.safe, 1'b0}) begin nFails++; $display("[TB] FAIL flagged_seed: got safe=%0d busy=%b want %0d 0", aSafeCnt, aBusy, e.safe); end
        e = '{safe: 9'd254, hit: 1'b0, won: 1'b0};
        sbq.push_back(e);
        startReveal(3, 3);
        waitIdle(0, 5000, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL flag_flood_timeout: busy=%b want 0", aBusy); end
        e = sbq.pop_front();
        nChecks++; if ({aSafeCnt, aHit, aWon} !== {e.safe, e.hit, e.won}) begin nFails++; $display("[TB] FAIL flag_flood_result: got safe=%0d hit=%b won=%b want %0d", aSafeCnt, aHit, aWon, e.safe); end
        setRd(10, 10);
        cursorAddr = 8'hAA;
        #1;
        nChecks++; if ({aRdFlag, aRdRev, aCurFlag, aCurRev} !== 4'b1010) begin nFails++; $display("[TB] FAIL flag_cell_state: got %b want 1010", {aRdFlag, aRdRev, aCurFlag, aCurRev}); end
        toggleFlag(3, 3);
        nChecks++; if (aFlagCnt !== 9'd1) begin nFails++; $display("[TB] FAIL flag_on_revealed: got %0d want 1", aFlagCnt); end
        toggleFlag(10, 10);
        nChecks++; if (aFlagCnt !== 9'd0) begin nFails++; $display("[TB] FAIL flag_count_clear: got %0d want 0", aFlagCnt); end
    endtask

    task automatic test_overflow();
        bit ok;
        int cnt;
        doClear();
        writeMine(15, 0, 1'b1);
        startReveal(0, 15);
        waitIdle(1, 20000, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL overflow_timeout: busy=%b want 0", sBusy); end
        nChecks++; if ({sOvf, sMineCnt} !== {1'b1, 9'd1}) begin nFails++; $display("[TB] FAIL overflow_flag: got ovf=%b mines=%0d want 1 1", sOvf, sMineCnt); end
        cnt = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                setRd(x, y);
                if (sRdRev) cnt++;
            end
        nChecks++; if (int'(sSafeCnt) != cnt) begin nFails++; $display("[TB] FAIL overflow_safe_count: got %0d want %0d", sSafeCnt, cnt); end
        nChecks++; if (sWon !== (cnt == 255)) begin nFails++; $display("[TB] FAIL overflow_won: got %b want %b", sWon, (cnt == 255)); end
    endtask

    task automatic test_small_grid();
        bit ok;
        int cnt;
        doClear();
        writeMine(8, 8, 1'b1);
        writeMine(12, 3, 1'b1);
        nChecks++; if (nMineCnt !== 7'd1) begin nFails++; $display("[TB] FAIL small_mine_count: got %0d want 1", nMineCnt); end
        e = '{safe: 9'd80, hit: 1'b0, won: 1'b1};
        sbq.push_back(e);
        startReveal(0, 0);
        waitIdle(2, 5000, ok);
        nChecks++; if (!ok) begin nFails++; $display("[TB] FAIL small_timeout: busy=%b want 0", nBusy); end
        tick();
        e = sbq.pop_front();
        nChecks++; if ({2'b00, nSafeCnt} !== e.safe) begin nFails++; $display("[TB] FAIL small_safe: got %0d want %0d", nSafeCnt, e.safe); end
        nChecks++; if ({nHit, nWon, nOvf} !== {e.hit, e.won, 1'b0}) begin nFails++; $display("[TB] FAIL small_status: got hit=%b won=%b ovf=%b want %b %b 0", nHit, nWon, nOvf, e.hit, e.won); end
        cnt = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                setRd(x, y);
                if (nRdRev) cnt++;
            end
        nChecks++; if (cnt != 80) begin nFails++; $display("[TB] FAIL small_revealed_cells: got %0d want 80", cnt); end
        setRd(12, 3);
        nChecks++; if ({nRdMine, nRdFlag, nRdRev, nRdAdj} !== 7'd0) begin nFails++; $display("[TB] FAIL out_of_grid_read: got %b want 0", {nRdMine, nRdFlag, nRdRev, nRdAdj}); end
        setRd(7, 7);
        nChecks++; if ({nRdRev, nRdAdj} !== 5'b1_0001) begin nFails++; $display("[TB] FAIL small_edge_adj: got rev=%b adj=%0d want 1 1", nRdRev, nRdAdj); end
        setRd(8, 8);
        nChecks++; if (nRdRev !== 1'b0) begin nFails++; $display("[TB] FAIL small_mine_hidden: got %b want 0", nRdRev); end
        dbg = 1'b1;
        #1;
        nChecks++; if (nRdRev !== 1'b1) begin nFails++; $display("[TB] FAIL debug_reveal: got %b want 1", nRdRev); end
        tick();
        nChecks++; if (nSafeCnt !== 7'd80) begin nFails++; $display("[TB] FAIL debug_safe_count: got %0d want 80", nSafeCnt); end
        dbg = 1'b0;
    endtask

    // Scenario sequence; each task checks its own results inline.
    initial begin
        #23 rstN = 1'b1;
        tick();
        test_reset();
        test_clear_mid_flood();
        test_full_flood();
        test_numbered_and_hit();
        test_flags();
        test_overflow();
        test_small_grid();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
